// File: rtl/wt_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// wt_mem_req_arbiter
// Shares the write-through cache memory request port between three requesters:
// icache refill (type 0), dcache load miss (type 1) and write-buffer store (type 2).
// It allocates the lowest free transaction ID to each granted request, caps the
// number of outstanding stores, and routes memory returns back to the owner.
//
// Optional feature: define WT_ARB_STORE_AGING_EN to add a store age counter.
// When the counter reaches AgeLimit, the store wins arbitration whenever it is
// eligible. Without the macro, arbitration is pure round-robin.
//
// Ports
//   clk_i, rst_i                     clock, async active-high reset
//   ic_req_valid_i/ready_o/addr_i    icache refill request
//   ld_req_valid_i/ready_o/addr_i    dcache load request
//   st_req_valid_i/ready_o/addr_i/data_i/be_i   write-buffer store request
//   mem_req_*_o, mem_req_ready_i     registered memory request (valid/ready)
//   mem_rtrn_valid_i, mem_rtrn_tid_i memory return
//   ic_rtrn_valid_o, dc_rtrn_valid_o return routing (same cycle as the return)
//   rtrn_err_o                       same-cycle pulse: return on a TID not in use
//   idle_o                           no TID in use and request register empty
// The *_req_ready_o, *_rtrn_valid_o and rtrn_err_o outputs are combinational
// by design: a grant or a return is answered in the cycle it is presented.
// -----------------------------------------------------------------------------
module wt_mem_req_arbiter #(
    parameter int unsigned TidWidth     = 2,
    parameter int unsigned MaxOutStores = 7,
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned AgeLimit     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ic_req_valid_i,
    output logic                   ic_req_ready_o,
    input  logic [AddrWidth-1:0]   ic_req_addr_i,
    input  logic                   ld_req_valid_i,
    output logic                   ld_req_ready_o,
    input  logic [AddrWidth-1:0]   ld_req_addr_i,
    input  logic                   st_req_valid_i,
    output logic                   st_req_ready_o,
    input  logic [AddrWidth-1:0]   st_req_addr_i,
    input  logic [DataWidth-1:0]   st_req_data_i,
    input  logic [DataWidth/8-1:0] st_req_be_i,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [1:0]             mem_req_type_o,
    output logic [AddrWidth-1:0]   mem_req_addr_o,
    output logic [DataWidth-1:0]   mem_req_data_o,
    output logic [DataWidth/8-1:0] mem_req_be_o,
    output logic [TidWidth-1:0]    mem_req_tid_o,
    input  logic                   mem_rtrn_valid_i,
    input  logic [TidWidth-1:0]    mem_rtrn_tid_i,
    output logic                   ic_rtrn_valid_o,
    output logic                   dc_rtrn_valid_o,
    output logic                   rtrn_err_o,
    output logic                   idle_o
);

    localparam int unsigned NumTid   = 1 << TidWidth;
    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned CntWidth = $clog2(NumTid + 1);
    // More stores in flight than TIDs is unreachable, so clamp the cap.
    localparam int unsigned StCap    = (MaxOutStores > NumTid) ? NumTid : MaxOutStores;

    typedef enum logic [1:0] {
        REQ_IFILL = 2'd0,
        REQ_LOAD  = 2'd1,
        REQ_STORE = 2'd2
    } req_type_e;

    // TID table, store counter, round-robin pointer (0 ic, 1 ld, 2 st)
    logic [NumTid-1:0]        r_tid_used;
    logic [NumTid-1:0][1:0]   r_tid_owner;
    logic [CntWidth-1:0]      r_st_cnt;
    logic [1:0]               r_rr_ptr;

    // Output request register
    logic                     r_req_valid;
    logic [1:0]               r_req_type;
    logic [AddrWidth-1:0]     r_req_addr;
    logic [DataWidth-1:0]     r_req_data;
    logic [BeWidth-1:0]       r_req_be;
    logic [TidWidth-1:0]      r_req_tid;

    logic                     w_slot_free;
    logic                     w_any_free;
    logic [TidWidth-1:0]      w_free_tid;
    logic [2:0]               w_elig;
    logic [2:0]               w_grant;
    logic                     w_age_force;
    req_type_e                w_win_type;
    logic                     w_rtrn_hit;
    logic                     w_st_inc;
    logic                     w_st_dec;

    assign w_slot_free = ~r_req_valid | mem_req_ready_i;
    assign w_any_free  = ~&r_tid_used;

    // Lowest free TID from the start-of-cycle table
    always_comb begin
        w_free_tid = '0;
        for (int i = int'(NumTid) - 1; i >= 0; i--) begin
            if (!r_tid_used[TidWidth'(i)]) begin
                w_free_tid = TidWidth'(i);
            end
        end
    end

    assign w_elig[0] = ic_req_valid_i & w_any_free;
    assign w_elig[1] = ld_req_valid_i & w_any_free;
    assign w_elig[2] = st_req_valid_i & w_any_free & (r_st_cnt < CntWidth'(StCap));

`ifdef WT_ARB_STORE_AGING_EN
    localparam int unsigned AgeWidth = (AgeLimit < 1) ? 1 : $clog2(AgeLimit + 1);

    logic [AgeWidth-1:0] r_st_age;

    assign w_age_force = (r_st_age >= AgeWidth'(AgeLimit)) & w_elig[2];

    // Counts cycles a store waits; saturates at the limit, clears on store grant
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_st_age <= '0;
        end else if (w_grant[2]) begin
            r_st_age <= '0;
        end else if (st_req_valid_i && (r_st_age < AgeWidth'(AgeLimit))) begin
            r_st_age <= r_st_age + AgeWidth'(1);
        end
    end
`else
    logic w_unused_age_limit;

    assign w_unused_age_limit = ^AgeLimit;
    assign w_age_force        = 1'b0;
`endif

    // Round-robin pick starting at the pointer; an aged store overrides it
    always_comb begin
        w_grant = 3'b000;
        if (w_slot_free) begin
            if (w_age_force) begin
                w_grant = 3'b100;
            end else begin
                unique case (r_rr_ptr)
                    2'd1: w_grant = w_elig[1] ? 3'b010 : w_elig[2] ? 3'b100 :
                                    w_elig[0] ? 3'b001 : 3'b000;
                    2'd2: w_grant = w_elig[2] ? 3'b100 : w_elig[0] ? 3'b001 :
                                    w_elig[1] ? 3'b010 : 3'b000;
                    default: w_grant = w_elig[0] ? 3'b001 : w_elig[1] ? 3'b010 :
                                       w_elig[2] ? 3'b100 : 3'b000;
                endcase
            end
        end
    end

    always_comb begin
        w_win_type = REQ_IFILL;
        if (w_grant[1]) begin
            w_win_type = REQ_LOAD;
        end else if (w_grant[2]) begin
            w_win_type = REQ_STORE;
        end
    end

    assign w_rtrn_hit = mem_rtrn_valid_i & r_tid_used[mem_rtrn_tid_i];
    assign w_st_inc   = w_grant[2];
    assign w_st_dec   = w_rtrn_hit & (r_tid_owner[mem_rtrn_tid_i] == REQ_STORE);

    // TID table, store count and round-robin pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tid_used  <= '0;
            r_tid_owner <= '0;
            r_st_cnt    <= '0;
            r_rr_ptr    <= 2'd0;
        end else begin
            // Grant takes a free TID, return frees a used one: never the same entry
            if (|w_grant) begin
                r_tid_used[w_free_tid]  <= 1'b1;
                r_tid_owner[w_free_tid] <= w_win_type;
                r_rr_ptr                <= w_grant[0] ? 2'd1 : w_grant[1] ? 2'd2 : 2'd0;
            end
            if (w_rtrn_hit) begin
                r_tid_used[mem_rtrn_tid_i] <= 1'b0;
            end
            if (w_st_inc && !w_st_dec) begin
                r_st_cnt <= r_st_cnt + CntWidth'(1);
            end else if (!w_st_inc && w_st_dec) begin
                r_st_cnt <= r_st_cnt - CntWidth'(1);
            end
        end
    end

    // Output request register: loads only when the slot is free
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_req_valid <= 1'b0;
            r_req_type  <= 2'd0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
            r_req_be    <= '0;
            r_req_tid   <= '0;
        end else if (w_slot_free) begin
            r_req_valid <= |w_grant;
            if (|w_grant) begin
                r_req_type <= w_win_type;
                r_req_tid  <= w_free_tid;
                r_req_addr <= w_grant[0] ? ic_req_addr_i :
                              w_grant[1] ? ld_req_addr_i : st_req_addr_i;
                r_req_data <= w_grant[2] ? st_req_data_i : '0;
                r_req_be   <= w_grant[2] ? st_req_be_i   : '0;
            end
        end
    end

    assign ic_req_ready_o  = w_grant[0];
    assign ld_req_ready_o  = w_grant[1];
    assign st_req_ready_o  = w_grant[2];

    assign mem_req_valid_o = r_req_valid;
    assign mem_req_type_o  = r_req_type;
    assign mem_req_addr_o  = r_req_addr;
    assign mem_req_data_o  = r_req_data;
    assign mem_req_be_o    = r_req_be;
    assign mem_req_tid_o   = r_req_tid;

    assign ic_rtrn_valid_o = w_rtrn_hit & (r_tid_owner[mem_rtrn_tid_i] == REQ_IFILL);
    assign dc_rtrn_valid_o = w_rtrn_hit & (r_tid_owner[mem_rtrn_tid_i] != REQ_IFILL);
    assign rtrn_err_o      = mem_rtrn_valid_i & ~r_tid_used[mem_rtrn_tid_i];
    assign idle_o          = ~|r_tid_used & ~r_req_valid;

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Testbench for wt_mem_req_arbiter: a transaction-level reference model predicts
// grants, return routing and idle; predicted memory requests go to a scoreboard
// queue that an independent monitor checks whenever the DUT presents a request.
`timescale 1ns/1ps
module tb_wt_mem_req_arbiter;

    localparam int unsigned TidWidth = 2;
    localparam int unsigned NumTid   = 4;
    localparam int unsigned MaxSt    = 3;
    localparam int unsigned AW       = 64;
    localparam int unsigned DW       = 64;
    localparam int unsigned BW       = 8;
    localparam int unsigned AgeLimit = 4;
`ifdef WT_ARB_STORE_AGING_EN
    localparam bit Aging = 1'b1;
`else
    localparam bit Aging = 1'b0;
`endif

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                ic_req_valid_i, ic_req_ready_o;
    logic [AW-1:0]       ic_req_addr_i;
    logic                ld_req_valid_i, ld_req_ready_o;
    logic [AW-1:0]       ld_req_addr_i;
    logic                st_req_valid_i, st_req_ready_o;
    logic [AW-1:0]       st_req_addr_i;
    logic [DW-1:0]       st_req_data_i;
    logic [BW-1:0]       st_req_be_i;
    logic                mem_req_valid_o, mem_req_ready_i;
    logic [1:0]          mem_req_type_o;
    logic [AW-1:0]       mem_req_addr_o;
    logic [DW-1:0]       mem_req_data_o;
    logic [BW-1:0]       mem_req_be_o;
    logic [TidWidth-1:0] mem_req_tid_o;
    logic                mem_rtrn_valid_i;
    logic [TidWidth-1:0] mem_rtrn_tid_i;
    logic                ic_rtrn_valid_o, dc_rtrn_valid_o, rtrn_err_o, idle_o;

    wt_mem_req_arbiter #(
        .TidWidth(TidWidth), .MaxOutStores(MaxSt), .AddrWidth(AW),
        .DataWidth(DW), .AgeLimit(AgeLimit)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ic_req_valid_i(ic_req_valid_i), .ic_req_ready_o(ic_req_ready_o), .ic_req_addr_i(ic_req_addr_i),
        .ld_req_valid_i(ld_req_valid_i), .ld_req_ready_o(ld_req_ready_o), .ld_req_addr_i(ld_req_addr_i),
        .st_req_valid_i(st_req_valid_i), .st_req_ready_o(st_req_ready_o), .st_req_addr_i(st_req_addr_i),
        .st_req_data_i(st_req_data_i), .st_req_be_i(st_req_be_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_type_o(mem_req_type_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_data_o(mem_req_data_o), .mem_req_be_o(mem_req_be_o), .mem_req_tid_o(mem_req_tid_o),
        .mem_rtrn_valid_i(mem_rtrn_valid_i), .mem_rtrn_tid_i(mem_rtrn_tid_i),
        .ic_rtrn_valid_o(ic_rtrn_valid_o), .dc_rtrn_valid_o(dc_rtrn_valid_o),
        .rtrn_err_o(rtrn_err_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int              typ;
        longint unsigned addr;
        longint unsigned data;
        int              be;
        int              tid;
    } req_t;

    req_t exp_q[$];
    req_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   obs_st = 0;

    // Reference model: which TIDs are outstanding and who owns them, stores in
    // flight, whose turn it is, whether a request sits in the output slot.
    bit   m_used[NumTid];
    int   m_owner[NumTid];
    int   m_stcnt;
    int   m_turn;
    bit   m_valid;
    int   m_age;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NumTid; i++) begin
            m_used[i]  = 1'b0;
            m_owner[i] = 0;
        end
        m_stcnt = 0;
        m_turn  = 0;
        m_valid = 1'b0;
        m_age   = 0;
        exp_q.delete();
    endtask

    function automatic int pick_used();
        int cand[$];
        for (int i = 0; i < NumTid; i++) if (m_used[i]) cand.push_back(i);
        if (cand.size() == 0) return -1;
        return cand[$urandom_range(cand.size() - 1, 0)];
    endfunction

    // One clock cycle: drive inputs, predict and check at the falling edge.
    task automatic step(input bit icv, input bit ldv, input bit stv, input bit rdy,
                        input bit rv, input int rtid);
        bit  elig[3];
        bit  slot_free, hit, none_used;
        int  win, ftid, own;
        req_t e;
        ic_req_valid_i   = icv;
        ld_req_valid_i   = ldv;
        st_req_valid_i   = stv;
        ic_req_addr_i    = {$urandom, $urandom};
        ld_req_addr_i    = {$urandom, $urandom};
        st_req_addr_i    = {$urandom, $urandom};
        st_req_data_i    = {$urandom, $urandom};
        st_req_be_i      = BW'($urandom);
        mem_req_ready_i  = rdy;
        mem_rtrn_valid_i = rv;
        mem_rtrn_tid_i   = TidWidth'(rtid);
        @(negedge clk_i);
        slot_free = !m_valid || rdy;
        ftid = -1;
        none_used = 1'b1;
        for (int i = NumTid - 1; i >= 0; i--) begin
            if (!m_used[i]) ftid = i;
            else none_used = 1'b0;
        end
        elig[0] = icv && ftid >= 0;
        elig[1] = ldv && ftid >= 0;
        elig[2] = stv && ftid >= 0 && m_stcnt < MaxSt;
        win = -1;
        if (slot_free) begin
            if (Aging && m_age >= AgeLimit && elig[2]) win = 2;
            else for (int k = 0; k < 3; k++) if (win < 0 && elig[(m_turn + k) % 3]) win = (m_turn + k) % 3;
        end
        chk("ic_ready", ic_req_ready_o, win == 0);
        chk("ld_ready", ld_req_ready_o, win == 1);
        chk("st_ready", st_req_ready_o, win == 2);
        chk("req_valid", mem_req_valid_o, m_valid);
        chk("idle", idle_o, none_used && !m_valid);
        hit = rv && m_used[rtid];
        own = m_owner[rtid];
        chk("ic_rtrn", ic_rtrn_valid_o, hit && own == 0);
        chk("dc_rtrn", dc_rtrn_valid_o, hit && own != 0);
        chk("rtrn_err", rtrn_err_o, rv && !m_used[rtid]);
        if (st_req_ready_o) obs_st++;
        if (win >= 0) begin
            e.typ  = win;
            e.tid  = ftid;
            e.addr = (win == 0) ? ic_req_addr_i : (win == 1) ? ld_req_addr_i : st_req_addr_i;
            e.data = (win == 2) ? st_req_data_i : 64'd0;
            e.be   = (win == 2) ? int'(st_req_be_i) : 0;
            exp_q.push_back(e);
            m_used[ftid]  = 1'b1;
            m_owner[ftid] = win;
            m_turn = (win + 1) % 3;
            if (win == 2) m_stcnt++;
        end
        if (hit) begin
            m_used[rtid] = 1'b0;
            if (own == 2) m_stcnt--;
        end
        if (slot_free) m_valid = (win >= 0);
        if (win == 2) m_age = 0;
        else if (stv && m_age < AgeLimit) m_age++;
        @(posedge clk_i);
        #1;
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        ic_req_valid_i   = 1'b0;
        ld_req_valid_i   = 1'b0;
        st_req_valid_i   = 1'b0;
        mem_req_ready_i  = 1'b0;
        mem_rtrn_valid_i = 1'b0;
        mem_rtrn_tid_i   = '0;
        rst_i = 1'b1;
        model_reset();
        #1;
        chk("rst_req_valid", mem_req_valid_o, 0);
        chk("rst_idle", idle_o, 1);
        chk("rst_readys", {ic_req_ready_o, ld_req_ready_o, st_req_ready_o}, 0);
        chk("rst_rtrn", {ic_rtrn_valid_o, dc_rtrn_valid_o, rtrn_err_o}, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Monitor: every presented request must match the oldest predicted one.
    always @(negedge clk_i) begin
        if (!rst_i && mem_req_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("req_unexpected", 1, 0);
            end else begin
                mon_e = exp_q[0];
                chk("req_type", mem_req_type_o, mon_e.typ);
                chk("req_tid", mem_req_tid_o, mon_e.tid);
                chk("req_addr", mem_req_addr_o, mon_e.addr);
                chk("req_data", mem_req_data_o, mon_e.data);
                chk("req_be", mem_req_be_o, mon_e.be);
                if (mem_req_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int r, waited;
        rst_i = 1'b0;
        mem_req_ready_i = 1'b0;
        #2;
        do_reset();

        // All three at once: ic, ld, st on consecutive cycles with TIDs 0,1,2
        repeat (3) step(1, 1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Back-pressure with a load pending: request held, no new grants
        step(0, 1, 0, 1, 1, 0);
        repeat (3) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Four loads fill the table; fifth blocked; return tid 2 then regrant it
        do_reset();
        repeat (5) step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 1, 1, 2);
        step(0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Store cap: eight store cycles issue only MaxSt stores
        do_reset();
        obs_st = 0;
        repeat (8) step(0, 0, 1, 1, 0, 0);
        chk("st_cap", obs_st, MaxSt);
        step(0, 0, 1, 1, 1, 0);
        step(0, 0, 1, 1, 1, 1);
        step(0, 0, 1, 1, 0, 0);

        // Return on an unused TID
        do_reset();
        step(0, 0, 0, 1, 1, 3);
        step(0, 0, 0, 1, 0, 0);

        // In-flight return after a mid-operation reset is an error
        step(1, 1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        do_reset();
        step(0, 0, 0, 1, 1, 0);

        // Store waiting behind streaming ic/ld traffic is served within 5 cycles
        do_reset();
        step(1, 1, 0, 1, 0, 0);
        obs_st = 0;
        waited = 0;
        while (obs_st == 0 && waited < 8) begin
            r = pick_used();
            step(1, 1, 1, 1, r >= 0, (r >= 0) ? r : 0);
            waited++;
        end
        chk("st_wait_bound", waited <= 5, 1);

        // Randomized traffic with occasional mid-operation resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(499, 0) == 0) begin
                do_reset();
            end else begin
                r = pick_used();
                if ($urandom_range(19, 0) == 0) r = $urandom_range(NumTid - 1, 0);
                else if ($urandom_range(9, 0) < 6) r = -1;
                step($urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(1, 0),
                     $urandom_range(9, 0) < 7, r >= 0, (r >= 0) ? r : 0);
            end
        end

        // Drain: accept everything and return every outstanding TID
        for (int c = 0; c < 20; c++) begin
            r = pick_used();
            step(0, 0, 0, 1, r >= 0, (r >= 0) ? r : 0);
        end
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_idle", idle_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
